// File: rtl/sram_mbist_ctrl.sv
// March C- MBIST controller for a single-port SRAM macro, one command per clock.
// Optional MBIST_FAIL_STOP_EN: abort the run at the first read mismatch.
module sram_mbist_ctrl #(
   parameter int unsigned       ADDR_W    = 10,
   parameter int unsigned       DATA_W    = 64,
   parameter int unsigned       NUM_WORDS = 1024,
   parameter logic [DATA_W-1:0] BG        = {DATA_W{1'b0}},
   parameter logic [2:0]        WTSEL_VAL = 3'b000,
   parameter logic [1:0]        RTSEL_VAL = 2'b00
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_bits,
   output logic              CEB,
   output logic              WEB,
   output logic [ADDR_W-1:0] A,
   output logic [DATA_W-1:0] D,
   output logic [DATA_W-1:0] BWEB,
   output logic [2:0]        WTSEL,
   output logic [1:0]        RTSEL,
   input  logic [DATA_W-1:0] Q
);

   typedef enum logic [3:0] {
      StIdle, StM0, StM1, StM2, StM3, StM4, StM5, StDrain, StDone
   } state_e;

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_WORDS - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                phase_q, phase_d;   // 0: read op, 1: write op of a two-op element
   logic                rd_pend_q;
   logic [DATA_W-1:0]   exp_q;
   logic [ADDR_W-1:0]   exp_addr_q;
   logic                fail_q;
   logic [ADDR_W-1:0]   fail_addr_q;
   logic [DATA_W-1:0]   fail_bits_q;

   logic                cmd_vld, cmd_rd, two_op, desc;
   logic [DATA_W-1:0]   cmd_data;
   logic                launch, mismatch, last_op, at_end;

   assign launch   = ((state_q == StIdle) || (state_q == StDone)) && start;
   assign mismatch = rd_pend_q && (Q != exp_q);
   assign last_op  = !two_op || phase_q;
   assign at_end   = desc ? (addr_q == '0) : (addr_q == LastAddr);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      phase_d = phase_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StM0;
               addr_d  = '0;
               phase_d = 1'b0;
            end
         end
         StM0, StM1, StM2, StM3, StM4, StM5: begin
            if (last_op) begin
               phase_d = 1'b0;
               if (at_end) begin
                  state_d = state_e'(state_q + 4'd1);
                  // M3 and M4 are the descending elements
                  addr_d  = ((state_q == StM2) || (state_q == StM3)) ? LastAddr : '0;
               end else begin
                  addr_d  = desc ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
               end
            end else begin
               phase_d = 1'b1;
            end
         end
         StDrain: state_d = StDone;
         default: state_d = StIdle;
      endcase
`ifdef MBIST_FAIL_STOP_EN
      if (mismatch && !fail_q) state_d = StDone;
`endif
   end

   // cmd_data is the write data for writes and the expected value for reads
   always_comb begin
      cmd_vld  = 1'b0;
      cmd_rd   = 1'b0;
      two_op   = 1'b0;
      desc     = 1'b0;
      cmd_data = BG;
      case (state_q)
         StM0: cmd_vld = 1'b1;
         StM1, StM3: begin
            cmd_vld  = 1'b1;
            two_op   = 1'b1;
            desc     = (state_q == StM3);
            cmd_rd   = !phase_q;
            cmd_data = phase_q ? ~BG : BG;
         end
         StM2, StM4: begin
            cmd_vld  = 1'b1;
            two_op   = 1'b1;
            desc     = (state_q == StM4);
            cmd_rd   = !phase_q;
            cmd_data = phase_q ? BG : ~BG;
         end
         StM5: begin
            cmd_vld = 1'b1;
            cmd_rd  = 1'b1;
         end
         default: ;
      endcase
      CEB   = !cmd_vld;
      WEB   = !(cmd_vld && !cmd_rd);
      A     = cmd_vld ? addr_q : '0;
      D     = (cmd_vld && !cmd_rd) ? cmd_data : '0;
      BWEB  = cmd_vld ? '0 : '1;
      WTSEL = WTSEL_VAL;
      RTSEL = RTSEL_VAL;
      busy  = (state_q != StIdle) && (state_q != StDone);
      done  = (state_q == StDone);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         addr_q      <= '0;
         phase_q     <= 1'b0;
         rd_pend_q   <= 1'b0;
         exp_q       <= '0;
         exp_addr_q  <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_bits_q <= '0;
      end else begin
         addr_q     <= addr_d;
         phase_q    <= phase_d;
         rd_pend_q  <= cmd_vld && cmd_rd;
         exp_q      <= cmd_data;
         exp_addr_q <= addr_q;
         if (launch) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_bits_q <= '0;
         end else if (mismatch && !fail_q) begin
            fail_q      <= 1'b1;
            fail_addr_q <= exp_addr_q;
            fail_bits_q <= Q ^ exp_q;
         end
      end
   end

   assign fail      = fail_q;
   assign fail_addr = fail_addr_q;
   assign fail_bits = fail_bits_q;

endmodule

// File: tb/tb_sram_mbist_ctrl.sv
// Directed bench for sram_mbist_ctrl with a behavioural SRAM and optional stuck-at fault.
module tb_sram_mbist_ctrl;

   localparam int AW = 10;
   localparam int DW = 64;
   localparam int N  = 1024;
`ifdef MBIST_FAIL_STOP_EN
   localparam int FaultDone = 2370;
   localparam int FaultCmds = 2370;
`else
   localparam int FaultDone = 10241;
   localparam int FaultCmds = 10240;
`endif

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, fail, CEB, WEB;
   logic [AW-1:0] fail_addr, A;
   logic [DW-1:0] fail_bits, D, BWEB;
   logic [2:0]    WTSEL;
   logic [1:0]    RTSEL;
   logic [DW-1:0] Q = '0;

   int n_checks = 0;
   int n_fail   = 0;

   sram_mbist_ctrl dut (
      .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_bits(fail_bits), .CEB(CEB), .WEB(WEB), .A(A), .D(D),
      .BWEB(BWEB), .WTSEL(WTSEL), .RTSEL(RTSEL), .Q(Q)
   );

   always #5 CLK = ~CLK;

   // SRAM model with a stuck-at-1 on bit 5 of word 0x2A0 when fault_en is set
   logic [DW-1:0] mem [N];
   logic          fault_en = 1'b0;
   always @(posedge CLK) begin
      if (!CEB) begin
         if (!WEB) mem[A] <= (mem[A] & BWEB) | (D & ~BWEB);
         else      Q <= mem[A] | ((fault_en && A == 10'h2A0) ? 64'h20 : 64'h0);
      end
   end

   int            cyc = 0;
   int            n_wr = 0, n_rd = 0;
   logic          mon_clr = 1'b0;
   logic [AW-1:0] first_a, m3r_a, m3w_a, last_a;
   logic          first_web, m3r_web, m3w_web, last_web;
   logic [DW-1:0] first_d, m3w_d;
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (mon_clr) begin
         n_wr <= 0;
         n_rd <= 0;
      end else if (!CEB) begin
         if (n_wr + n_rd == 0) begin
            first_a <= A; first_web <= WEB; first_d <= D;
         end
         if (n_wr + n_rd == 5*N) begin
            m3r_a <= A; m3r_web <= WEB;
         end
         if (n_wr + n_rd == 5*N + 1) begin
            m3w_a <= A; m3w_web <= WEB; m3w_d <= D;
         end
         last_a <= A; last_web <= WEB;
         if (!WEB) n_wr <= n_wr + 1;
         else      n_rd <= n_rd + 1;
      end
   end

   task automatic clear_mon();
      @(negedge CLK); mon_clr = 1'b1;
      @(negedge CLK); mon_clr = 1'b0;
   endtask

   task automatic pulse_start(output int t);
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); #1; t = cyc;
      @(negedge CLK); start = 1'b0;
   endtask

   task automatic wait_done(output int te);
      te = -1;
      for (int i = 0; i < 20000; i++) begin
         @(negedge CLK);
         if (done) begin
            te = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      n_checks++; if ({busy, done, fail, CEB, WEB} !== 5'b00011) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 00011", {busy, done, fail, CEB, WEB});
      end
      n_checks++; if (fail_addr !== '0 || fail_bits !== '0) begin
         n_fail++; $display("FAIL reset_fail_regs: got %h/%h want 0/0", fail_addr, fail_bits);
      end
      n_checks++; if (A !== '0 || D !== '0 || BWEB !== {DW{1'b1}}) begin
         n_fail++; $display("FAIL reset_pins: got A=%h D=%h BWEB=%h", A, D, BWEB);
      end
      n_checks++; if (WTSEL !== 3'b000 || RTSEL !== 2'b00) begin
         n_fail++; $display("FAIL reset_tsel: got %b/%b want 000/00", WTSEL, RTSEL);
      end
      @(negedge CLK); RST = 1'b0;
   endtask

   task automatic test_march();
      int t, te;
      clear_mon();
      pulse_start(t);
      n_checks++; if (busy !== 1'b1) begin
         n_fail++; $display("FAIL march_busy: got %b want 1", busy);
      end
      wait_done(te);
      n_checks++; if (te - t !== 10241) begin
         n_fail++; $display("FAIL march_latency: got %0d want 10241", te - t);
      end
      n_checks++; if (fail !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL march_status: got fail=%b busy=%b want 0 0", fail, busy);
      end
      n_checks++; if (n_wr !== 5120 || n_rd !== 5120) begin
         n_fail++; $display("FAIL march_counts: got wr=%0d rd=%0d want 5120 5120", n_wr, n_rd);
      end
      n_checks++; if (first_a !== 10'h000 || first_web !== 1'b0 || first_d !== '0) begin
         n_fail++; $display("FAIL march_first: got A=%h WEB=%b D=%h", first_a, first_web, first_d);
      end
      n_checks++; if (m3r_a !== 10'h3FF || m3r_web !== 1'b1) begin
         n_fail++; $display("FAIL march_m3_read: got A=%h WEB=%b want 3ff 1", m3r_a, m3r_web);
      end
      n_checks++; if (m3w_a !== 10'h3FF || m3w_web !== 1'b0 || m3w_d !== {DW{1'b1}}) begin
         n_fail++; $display("FAIL march_m3_write: got A=%h WEB=%b D=%h", m3w_a, m3w_web, m3w_d);
      end
      n_checks++; if (last_a !== 10'h3FF || last_web !== 1'b1) begin
         n_fail++; $display("FAIL march_last: got A=%h WEB=%b want 3ff 1", last_a, last_web);
      end
   endtask

   task automatic test_stuck_at();
      int t, te, cmds;
      fault_en = 1'b1;
      clear_mon();
      pulse_start(t);
      wait_done(te);
      n_checks++; if (te - t !== FaultDone) begin
         n_fail++; $display("FAIL stuck_latency: got %0d want %0d", te - t, FaultDone);
      end
      n_checks++; if (fail !== 1'b1 || fail_addr !== 10'h2A0) begin
         n_fail++; $display("FAIL stuck_addr: got fail=%b addr=%h want 1 2a0", fail, fail_addr);
      end
      n_checks++; if (fail_bits !== 64'h20) begin
         n_fail++; $display("FAIL stuck_bits: got %h want 20", fail_bits);
      end
      cmds = n_wr + n_rd;
      n_checks++; if (cmds !== FaultCmds) begin
         n_fail++; $display("FAIL stuck_cmds: got %0d want %0d", cmds, FaultCmds);
      end
      repeat (20) @(negedge CLK);
      n_checks++; if (n_wr + n_rd !== cmds || busy !== 1'b0) begin
         n_fail++; $display("FAIL stuck_quiet: got %0d cmds busy=%b want %0d 0", n_wr + n_rd, busy, cmds);
      end
      fault_en = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int t, te;
      pulse_start(t);
      for (int i = 0; i < 1000 && cyc < t + 500; i++) @(negedge CLK);
      n_checks++; if (busy !== 1'b1 || CEB !== 1'b0) begin
         n_fail++; $display("FAIL midrst_before: got busy=%b CEB=%b want 1 0", busy, CEB);
      end
      RST = 1'b1;
      #1;
      n_checks++; if ({CEB, busy, done, fail} !== 4'b1000) begin
         n_fail++; $display("FAIL midrst_async: got %b want 1000", {CEB, busy, done, fail});
      end
      @(negedge CLK); RST = 1'b0;
      pulse_start(t);
      wait_done(te);
      n_checks++; if (te - t !== 10241 || fail !== 1'b0) begin
         n_fail++; $display("FAIL midrst_rerun: got %0d fail=%b want 10241 0", te - t, fail);
      end
   endtask

   task automatic test_start_held();
      int t, te;
      fault_en = 1'b1;
      clear_mon();
      @(negedge CLK); start = 1'b1;
      @(posedge CLK); #1; t = cyc;
      wait_done(te);
      n_checks++; if (te - t !== FaultDone || n_wr + n_rd !== FaultCmds) begin
         n_fail++; $display("FAIL held_one_run: got %0d cyc %0d cmds want %0d %0d",
                            te - t, n_wr + n_rd, FaultDone, FaultCmds);
      end
      n_checks++; if (fail !== 1'b1) begin
         n_fail++; $display("FAIL held_fail: got %b want 1", fail);
      end
      @(posedge CLK); #1;
      n_checks++; if ({done, fail, busy} !== 3'b001 || fail_addr !== '0) begin
         n_fail++; $display("FAIL held_relaunch: got done/fail/busy=%b addr=%h want 001 0",
                            {done, fail, busy}, fail_addr);
      end
      start = 1'b0;
      fault_en = 1'b0;
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK); RST = 1'b0;
   endtask

   initial begin
      test_reset();
      test_march();
      test_stuck_at();
      test_reset_mid_run();
      test_start_held();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
